// File: rtl/dma_job_scheduler_pkg.sv
// Shared constants for the DMA job scheduler: FSM encodings, CSR map and status layout.
package dma_sched_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD_ADDR = 3'd1;
  localparam logic [2:0] S_LOAD_CNT  = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;
  localparam logic [2:0] S_ERR       = 3'd5;

  typedef enum logic [1:0] {
    CSR_STAGE = 2'd0,
    CSR_JOB   = 2'd1,
    CSR_CTRL  = 2'd2,
    CSR_DONE  = 2'd3
  } csr_off_e;

  localparam int ST_EN        = 0;
  localparam int ST_BUSY      = 1;
  localparam int ST_ERR       = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_LEVEL_LSB = 16;

  localparam int BEAT_BYTES = 8;

  function automatic logic [31:0] pack_status(input logic [15:0] level, input logic ovf,
                                              input logic err, input logic busy, input logic en);
    logic [31:0] w;
    w                              = 32'd0;
    w[ST_LEVEL_LSB +: 16]          = level;
    w[ST_OVF]                      = ovf;
    w[ST_ERR]                      = err;
    w[ST_BUSY]                     = busy;
    w[ST_EN]                       = en;
    return w;
  endfunction

endpackage

// File: rtl/dma_job_scheduler_if.sv
// Host CSR slave plus DMAMaster ctrl/irq bundle; slave = scheduler side, master = environment side.
interface dma_job_scheduler_if;
  logic [1:0]  csr_address;
  logic        csr_write;
  logic [31:0] csr_writedata;
  logic        csr_read;
  logic [31:0] csr_readdata;
  logic        dma_ctrl_write;
  logic        dma_ctrl_address;
  logic [31:0] dma_ctrl_writedata;
  logic        dma_ctrl_waitrequest;
  logic        dma_irq;
  logic        irq;

  modport slave (
    input  csr_address, csr_write, csr_writedata, csr_read, dma_ctrl_waitrequest, dma_irq,
    output csr_readdata, dma_ctrl_write, dma_ctrl_address, dma_ctrl_writedata, irq
  );

  modport master (
    output csr_address, csr_write, csr_writedata, csr_read, dma_ctrl_waitrequest, dma_irq,
    input  csr_readdata, dma_ctrl_write, dma_ctrl_address, dma_ctrl_writedata, irq
  );
endinterface

// File: rtl/dma_job_scheduler_job_fifo.sv
// Synchronous first-word-fall-through FIFO holding queued DMA jobs.
module job_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == FULL_LVL);
  assign o_empty   = (r_level == {(AW+1){1'b0}});
  assign o_level   = r_level;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage array; contents are don't-care while the level says empty.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {(AW+1){1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/dma_job_scheduler.sv
// DMA job scheduler: queues host write jobs and launches them one at a time on DMAMaster,
// counting completions and flagging jobs that never finish.
module dma_job_scheduler #(
  parameter int DEPTH   = 8,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 2**20
) (
  input logic                clk,
  input logic                reset,
  dma_job_scheduler_if.slave bus
);
  import dma_sched_pkg::*;

  localparam int JW   = 32 + LEN_W;
  localparam int LW   = $clog2(DEPTH) + 1;
  localparam int WD_W = $clog2(TIMEOUT);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic             r_en;
  logic             r_err;
  logic             r_ovf;
  logic             r_irq;
  logic [31:0]      r_stage;
  logic [31:0]      r_done_cnt;
  logic [31:0]      r_rdata;
  logic             r_dma_write;
  logic             r_dma_addr;
  logic [31:0]      r_dma_data;
  logic [WD_W-1:0]  r_wd;

  logic             w_full;
  logic             w_empty;
  logic [LW-1:0]    w_level;
  logic [JW-1:0]    w_job_in;
  logic [JW-1:0]    w_head;
  logic [31:0]      w_head_addr;
  logic [LEN_W-1:0] w_head_len;
  logic [31:0]      w_cnt_word;
  logic [LEN_W-1:0] w_len;
  logic             w_push_req;
  logic             w_push_ok;
  logic             w_drop;
  logic             w_ctrl_wr;
  logic             w_clear;
  logic             w_irq_w1c;
  logic             w_pop;
  logic             w_done_set;
  logic             w_err_set;
  logic             w_busy;

  assign w_len       = bus.csr_writedata[LEN_W-1:0];
  assign w_push_req  = bus.csr_write & (bus.csr_address == CSR_JOB);
  assign w_push_ok   = w_push_req & (w_len != {LEN_W{1'b0}}) & ~w_full;
  assign w_drop      = w_push_req & ~w_push_ok;
  assign w_ctrl_wr   = bus.csr_write & (bus.csr_address == CSR_CTRL);
  assign w_clear     = w_ctrl_wr & bus.csr_writedata[1];
  assign w_irq_w1c   = bus.csr_write & (bus.csr_address == CSR_DONE) & bus.csr_writedata[0];
  assign w_job_in    = {r_stage, w_len};
  assign w_head_addr = w_head[JW-1:LEN_W];
  assign w_head_len  = w_head[LEN_W-1:0];
  // DMAMaster runs count+1 beats, so the programmed count is one less than the job length.
  assign w_cnt_word  = 32'(w_head_len - LEN_W'(1));
  assign w_pop       = (r_state == S_LOAD_CNT) & ~bus.dma_ctrl_waitrequest;
  assign w_done_set  = (r_state == S_RUN) & (w_state_nxt == S_DONE);
  assign w_err_set   = (r_state == S_RUN) & (w_state_nxt == S_ERR);
  assign w_busy      = (r_state != S_IDLE);

  job_fifo #(.WIDTH(JW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push_ok),
    .i_data  (w_job_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_en && !w_empty && !r_err) w_state_nxt = S_LOAD_ADDR;
        else                            w_state_nxt = S_IDLE;
      end
      S_LOAD_ADDR: begin
        if (!bus.dma_ctrl_waitrequest) w_state_nxt = S_LOAD_CNT;
        else                           w_state_nxt = S_LOAD_ADDR;
      end
      S_LOAD_CNT: begin
        if (!bus.dma_ctrl_waitrequest) w_state_nxt = S_RUN;
        else                           w_state_nxt = S_LOAD_CNT;
      end
      S_RUN: begin
        if (bus.dma_irq)                          w_state_nxt = S_DONE;
        else if (r_wd == WD_W'(TIMEOUT - 1))      w_state_nxt = S_ERR;
        else                                      w_state_nxt = S_RUN;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR: begin
        if (w_clear) w_state_nxt = S_IDLE;
        else         w_state_nxt = S_ERR;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state, registered DMAMaster ctrl outputs and watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_dma_write <= 1'b0;
      r_dma_addr  <= 1'b0;
      r_dma_data  <= 32'd0;
      r_wd        <= {WD_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_dma_write <= (w_state_nxt == S_LOAD_ADDR) | (w_state_nxt == S_LOAD_CNT);
      r_dma_addr  <= (w_state_nxt == S_LOAD_CNT);
      r_dma_data  <= (w_state_nxt == S_LOAD_CNT)  ? w_cnt_word :
                     (w_state_nxt == S_LOAD_ADDR) ? w_head_addr : 32'd0;
      r_wd        <= (r_state == S_RUN) ? r_wd + WD_W'(1) : {WD_W{1'b0}};
    end
  end

  // CSR registers, sticky flags, completion counter and host irq (set beats W1C).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_en       <= 1'b0;
      r_stage    <= 32'd0;
      r_ovf      <= 1'b0;
      r_err      <= 1'b0;
      r_irq      <= 1'b0;
      r_done_cnt <= 32'd0;
      r_rdata    <= 32'd0;
    end else begin
      if (bus.csr_write && bus.csr_address == CSR_STAGE) r_stage <= bus.csr_writedata;
      if (w_ctrl_wr) r_en <= bus.csr_writedata[0];
      if (w_drop)       r_ovf <= 1'b1;
      else if (w_clear) r_ovf <= 1'b0;
      if (w_err_set)    r_err <= 1'b1;
      else if (w_clear) r_err <= 1'b0;
      if (w_done_set) r_done_cnt <= r_done_cnt + 32'd1;
      if (w_done_set || w_err_set) r_irq <= 1'b1;
      else if (w_irq_w1c)          r_irq <= 1'b0;
      if (bus.csr_read) begin
        case (bus.csr_address)
          CSR_STAGE: r_rdata <= r_stage;
          CSR_JOB:   r_rdata <= pack_status(16'(w_level), r_ovf, r_err, w_busy, r_en);
          CSR_CTRL:  r_rdata <= {31'd0, r_en};
          CSR_DONE:  r_rdata <= r_done_cnt;
          default:   r_rdata <= 32'd0;
        endcase
      end
    end
  end

  assign bus.csr_readdata       = r_rdata;
  assign bus.dma_ctrl_write     = r_dma_write;
  assign bus.dma_ctrl_address   = r_dma_addr;
  assign bus.dma_ctrl_writedata = r_dma_data;
  assign bus.irq                = r_irq;

endmodule

// File: tb/tb_dma_job_scheduler.sv
// Scoreboard bench for dma_job_scheduler with a DMAMaster model driving random ctrl_waitrequest.
module tb_dma_job_scheduler;
  import dma_sched_pkg::*;

  localparam int DEPTH   = 8;
  localparam int LEN_W   = 16;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dma_job_scheduler_if bif();

  dma_job_scheduler #(.DEPTH(DEPTH), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        addr_bit;
    logic [31:0] data;
  } ctrl_wr_t;

  ctrl_wr_t exp_q[$];
  int n_total     = 0;
  int n_bad       = 0;
  int n_beats     = 0;
  int n_bytes     = 0;
  int n_count_acc = 0;
  int m_left      = 0;
  bit m_busy      = 1'b0;
  bit sup_irq     = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // DMAMaster model: accepts ctrl writes, checks them against the scoreboard, runs beats, pulses irq.
  initial begin
    ctrl_wr_t e;
    bif.dma_irq              = 1'b0;
    bif.dma_ctrl_waitrequest = 1'b0;
    forever begin
      @(negedge clk);
      bif.dma_irq = 1'b0;
      if (rst) begin
        m_busy                   = 1'b0;
        m_left                   = 0;
        bif.dma_ctrl_waitrequest = 1'b0;
      end else begin
        if (m_busy) begin
          m_left--;
          n_beats++;
          n_bytes += BEAT_BYTES;
          if (m_left == 0) begin
            m_busy = 1'b0;
            if (!sup_irq) bif.dma_irq = 1'b1;
          end
        end
        bif.dma_ctrl_waitrequest = ($urandom_range(0, 2) == 0);
        if (bif.dma_ctrl_write && !bif.dma_ctrl_waitrequest) begin
          if (exp_q.size() == 0) begin
            check_val("unexpected_ctrl_write", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check_val("ctrl_address", 32'(bif.dma_ctrl_address), 32'(e.addr_bit));
            check_val("ctrl_writedata", bif.dma_ctrl_writedata, e.data);
          end
          if (!bif.dma_ctrl_address) begin
            check_val("no_overlap", 32'(m_busy), 32'd0);
          end else begin
            m_busy = 1'b1;
            m_left = int'(bif.dma_ctrl_writedata) + 1;
            n_count_acc++;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    bif.csr_address   = a;
    bif.csr_writedata = d;
    bif.csr_write     = 1'b1;
    tick(1);
    bif.csr_write     = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    bif.csr_address = a;
    bif.csr_read    = 1'b1;
    tick(1);
    bif.csr_read    = 1'b0;
    d               = bif.csr_readdata;
  endtask

  task automatic push_job(input logic [31:0] addr, input logic [15:0] len, input bit ok);
    ctrl_wr_t e;
    csr_wr(CSR_STAGE, addr);
    csr_wr(CSR_JOB, {16'd0, len});
    if (ok) begin
      e.addr_bit = 1'b0;
      e.data     = addr;
      exp_q.push_back(e);
      e.addr_bit = 1'b1;
      e.data     = 32'(len) - 32'd1;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string tag, input logic [31:0] target, input int budget);
    logic [31:0] v;
    int k;
    k = 0;
    csr_rd(CSR_DONE, v);
    while (v !== target && k < budget) begin
      csr_rd(CSR_DONE, v);
      k++;
    end
    check_val(tag, v, target);
  endtask

  task automatic wait_launch(input string tag, input int prev, input int budget);
    int k;
    k = 0;
    while (n_count_acc == prev && k < budget) begin
      tick(1);
      k++;
    end
    check_val(tag, 32'(n_count_acc != prev), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL tb_time_limit: got=%0d exp=%0d", n_total, 0);
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int          n;
    int          acc;
    bif.csr_address   = 2'd0;
    bif.csr_write     = 1'b0;
    bif.csr_writedata = 32'd0;
    bif.csr_read      = 1'b0;

    // Reset state
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check_val("rst_ctrl_write", 32'(bif.dma_ctrl_write), 32'd0);
    check_val("rst_ctrl_address", 32'(bif.dma_ctrl_address), 32'd0);
    check_val("rst_ctrl_writedata", bif.dma_ctrl_writedata, 32'd0);
    check_val("rst_irq", 32'(bif.irq), 32'd0);
    check_val("rst_readdata", bif.csr_readdata, 32'd0);
    csr_rd(CSR_JOB, v);
    check_val("rst_status", v, 32'd0);
    csr_rd(CSR_DONE, v);
    check_val("rst_done_count", v, 32'd0);

    // Single job {0x1000, 4}
    n_beats = 0;
    n_bytes = 0;
    push_job(32'h0000_1000, 16'd4, 1'b1);
    csr_wr(CSR_CTRL, 32'd1);
    wait_done("t1_done_count", 32'd1, 300);
    check_val("t1_irq", 32'(bif.irq), 32'd1);
    check_val("t1_beats", 32'(n_beats), 32'd4);
    check_val("t1_bytes", 32'(n_bytes), 32'd32);
    csr_wr(CSR_DONE, 32'd1);
    check_val("t1_irq_w1c", 32'(bif.irq), 32'd0);

    // Three jobs queued while disabled, launched in order
    csr_wr(CSR_CTRL, 32'd0);
    push_job(32'h0000_2000, 16'd1, 1'b1);
    push_job(32'h0000_3000, 16'd7, 1'b1);
    push_job(32'h0000_4000, 16'd2, 1'b1);
    csr_rd(CSR_JOB, v);
    check_val("t2_level3", 32'(v[31:16]), 32'd3);
    n_beats = 0;
    csr_wr(CSR_CTRL, 32'd1);
    wait_done("t2_done_count", 32'd4, 500);
    csr_rd(CSR_JOB, v);
    check_val("t2_level0", 32'(v[31:16]), 32'd0);
    check_val("t2_beats", 32'(n_beats), 32'd10);

    // DEPTH+1 pushes while disabled: last one overflows
    csr_wr(CSR_CTRL, 32'd0);
    for (int i = 0; i <= DEPTH; i++) begin
      push_job(32'h0001_0000 + 32'(i) * 32'h100, 16'(i + 1), i < DEPTH);
    end
    csr_rd(CSR_JOB, v);
    check_val("t3_full_status", v, 32'h0008_0008);
    csr_wr(CSR_CTRL, 32'd2);
    csr_rd(CSR_JOB, v);
    check_val("t3_ovf_cleared", v, 32'h0008_0000);
    n_beats = 0;
    csr_wr(CSR_CTRL, 32'd1);
    wait_done("t3_done_count", 32'd12, 1500);
    check_val("t3_beats", 32'(n_beats), 32'd36);

    // Zero-length push is dropped
    acc = n_count_acc;
    push_job(32'h0000_9000, 16'd0, 1'b0);
    csr_rd(CSR_JOB, v);
    check_val("t4_len0_status", v & 32'hFFFF_0009, 32'h0000_0009);
    tick(20);
    check_val("t4_len0_no_launch", 32'(n_count_acc), 32'(acc));
    csr_wr(CSR_CTRL, 32'd3);
    csr_rd(CSR_JOB, v);
    check_val("t4_ovf_cleared", v & 32'h0000_0009, 32'h0000_0001);

    // Watchdog: suppressed completion raises err/irq TIMEOUT cycles into RUN
    csr_wr(CSR_DONE, 32'd1);
    csr_wr(CSR_CTRL, 32'd0);
    sup_irq = 1'b1;
    push_job(32'h0000_5000, 16'd3, 1'b1);
    push_job(32'h0000_6000, 16'd2, 1'b1);
    acc = n_count_acc;
    csr_wr(CSR_CTRL, 32'd1);
    wait_launch("t5_launch", acc, 200);
    n = 0;
    while (!bif.irq && n < 4 * TIMEOUT) begin
      tick(1);
      n++;
    end
    check_val("t5_timeout_cycles", 32'(n), 32'(TIMEOUT));
    csr_rd(CSR_JOB, v);
    check_val("t5_err_status", v, 32'h0001_0007);
    sup_irq = 1'b0;
    csr_wr(CSR_DONE, 32'd1);
    csr_wr(CSR_CTRL, 32'd3);
    wait_done("t5_next_job_done", 32'd13, 300);
    csr_rd(CSR_JOB, v);
    check_val("t5_err_cleared", 32'(v[ST_ERR]), 32'd0);

    // Reset during RUN
    csr_wr(CSR_CTRL, 32'd0);
    push_job(32'h0000_7000, 16'd200, 1'b1);
    push_job(32'h0000_7100, 16'd3, 1'b1);
    acc = n_count_acc;
    csr_wr(CSR_CTRL, 32'd1);
    wait_launch("t6_launch", acc, 200);
    tick(5);
    rst = 1'b1;
    exp_q.delete();
    tick(1);
    check_val("t6_ctrl_write", 32'(bif.dma_ctrl_write), 32'd0);
    check_val("t6_ctrl_address", 32'(bif.dma_ctrl_address), 32'd0);
    check_val("t6_ctrl_writedata", bif.dma_ctrl_writedata, 32'd0);
    check_val("t6_irq", 32'(bif.irq), 32'd0);
    check_val("t6_readdata", bif.csr_readdata, 32'd0);
    rst = 1'b0;
    csr_rd(CSR_JOB, v);
    check_val("t6_status", v, 32'd0);
    csr_rd(CSR_DONE, v);
    check_val("t6_done_count", v, 32'd0);
    push_job(32'h0000_8000, 16'd5, 1'b1);
    csr_wr(CSR_CTRL, 32'd1);
    wait_done("t6_after_reset_done", 32'd1, 300);
    check_val("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
